rect_fetcher: RTL

Sequential loader that walks the rectangle table in video memory at frame start, converts each record (x, y, width, height, color) into the half-open bounds (left, top, right, bottom) used by the per-rect collision comparators, and writes them into the GPU rect register file one rect at a time. It sits between the video-memory read port and the rect register file, and is triggered once per frame by the display timing block.

---
 rtl/rect_fetcher.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/rect_fetcher.sv
`default_nettype none
// ============================================================================
// rect_fetcher : walks the video-memory rect table at frame start and writes
//                half-open bounds (left, top, right, bottom) plus color into
//                the rect register file, one rect per 7 cycles.
// Revision     : 1.0
// ============================================================================
module rect_fetcher #(
    parameter int                    COORD_WIDTH = 16,
    parameter int                    COLOR_WIDTH = 16,
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    RECT_COUNT  = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    IDX_WIDTH   = (RECT_COUNT > 1) ? $clog2(RECT_COUNT) : 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   mem_re,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic [15:0]            mem_rdata,
    output logic                   rect_we,
    output logic [IDX_WIDTH-1:0]   rect_idx,
    output logic [COORD_WIDTH-1:0] rect_left,
    output logic [COORD_WIDTH-1:0] rect_top,
    output logic [COORD_WIDTH-1:0] rect_right,
    output logic [COORD_WIDTH-1:0] rect_bottom,
    output logic [COLOR_WIDTH-1:0] rect_color
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WAIT  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [2:0]             r_k;
    logic [2:0]             r_k_d;
    logic                   r_re_d;
    logic [IDX_WIDTH-1:0]   r_idx;
    logic [ADDR_WIDTH-1:0]  r_ptr;
    logic [COORD_WIDTH-1:0] r_x;
    logic [COORD_WIDTH-1:0] r_y;
    logic [COORD_WIDTH-1:0] r_w;
    logic [COORD_WIDTH-1:0] r_h;
    logic                   r_done;
    logic                   w_last;
    logic [COORD_WIDTH:0]   w_sum_r;
    logic [COORD_WIDTH:0]   w_sum_b;

    assign w_last  = (r_idx == IDX_WIDTH'(RECT_COUNT - 1));
    // One extra bit catches the carry so the far edge saturates instead of wrapping.
    assign w_sum_r = {1'b0, r_x} + {1'b0, r_w};
    assign w_sum_b = {1'b0, r_y} + {1'b0, r_h};

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign mem_re   = (r_state == S_READ);
    assign mem_addr = r_ptr;
    assign rect_we  = (r_state == S_WRITE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_READ;
            S_READ:  if (r_k == 3'd4) w_next = S_WAIT;
            S_WAIT:  w_next = S_WRITE;
            S_WRITE: w_next = w_last ? S_IDLE : S_READ;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_k_d       <= '0;
            r_re_d      <= 1'b0;
            r_idx       <= '0;
            r_ptr       <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_w         <= '0;
            r_h         <= '0;
            r_done      <= 1'b0;
            rect_idx    <= '0;
            rect_left   <= '0;
            rect_top    <= '0;
            rect_right  <= '0;
            rect_bottom <= '0;
            rect_color  <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == S_WRITE) && w_last;
            r_re_d  <= mem_re;
            r_k_d   <= r_k;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_k   <= '0;
                        r_idx <= '0;
                        r_ptr <= BASE_ADDR;
                    end
                end
                S_READ: begin
                    r_ptr <= r_ptr + ADDR_WIDTH'(1);
                    r_k   <= r_k + 3'd1;
                end
                S_WAIT: begin
                    // Color arrives this cycle, so it goes straight to the output register.
                    rect_idx    <= r_idx;
                    rect_left   <= r_x;
                    rect_top    <= r_y;
                    rect_right  <= w_sum_r[COORD_WIDTH] ? '1 : w_sum_r[COORD_WIDTH-1:0];
                    rect_bottom <= w_sum_b[COORD_WIDTH] ? '1 : w_sum_b[COORD_WIDTH-1:0];
                    rect_color  <= COLOR_WIDTH'(mem_rdata);
                end
                S_WRITE: begin
                    if (!w_last) begin
                        r_idx <= r_idx + IDX_WIDTH'(1);
                        r_k   <= '0;
                    end
                end
                default: ;
            endcase

            if (r_re_d) begin
                case (r_k_d)
                    3'd0:    r_x <= COORD_WIDTH'(mem_rdata);
                    3'd1:    r_y <= COORD_WIDTH'(mem_rdata);
                    3'd2:    r_w <= COORD_WIDTH'(mem_rdata);
                    3'd3:    r_h <= COORD_WIDTH'(mem_rdata);
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
